udma_uart_rx_deser: RTL
=======================

// Module: udma_uart_rx_deser
// PURPOSE
//  Serial receive stage of the uDMA UART. It oversamples rx_i with the programmed divider and deframes
//  start/data/parity/stop bits. Each received character goes into a one-entry holding register and is
//  offered on a valid/ready port to the UART register interface and the RX DMA path. Parity and overflow
//  error strobes drive that interface's sticky error bits.
// PARAMETERS
//  SYNC_STAGES   2   flip-flop synchroniser depth on rx_i (>=2)
// PORTS
//  clk_i            in   1   system clock
//  rstn_i           in   1   asynchronous active-low reset
//  rx_i             in   1   serial line, idle high, asynchronous
//  cfg_en_i         in   1   receiver enable
//  cfg_div_i        in   16  bit period = cfg_div_i+1 clocks
//  cfg_bits_i       in   2   data bits = 5+cfg_bits_i (0..3 -> 5..8)
//  cfg_parity_en_i  in   1   even-parity bit present after data
//  cfg_stop_bits_i  in   1   0: one stop bit, 1: two stop bits
//  rx_data_o        out  8   received character, LSB first on wire, zero-extended
//  rx_valid_o       out  1   rx_data_o holds an unconsumed character
//  rx_ready_i       in   1   consumer accepts rx_data_o this cycle
//  err_parity_o     out  1   1-cycle pulse: parity mismatch on the completed frame
//  err_overflow_o   out  1   1-cycle pulse: frame completed while the holding register was full
//  busy_o           out  1   FSM not in IDLE
// BEHAVIOUR
//  - Reset: every output is 0. FSM is IDLE, holding register is 0, synchroniser flops are 1.
//  - FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
//  - Baud counter: counts 0..cfg_div_i, then wraps. Half period = (cfg_div_i+1)>>1 clocks.
//  - Config sampling: cfg_div/bits/parity/stop are latched on the IDLE->START transition.
//    Config changes mid-frame do not affect the current frame.
//  - IDLE: on cfg_en_i=1 and a synchronised 1->0 edge, go to START and load the counter for a half period.
//  - START: at the half point, sample the line.
//    Sample 1: false start, return to IDLE, nothing reported.
//    Sample 0: go to DATA. All later samples are taken every full bit period, at mid-bit.
//  - DATA: shift in 5+bits samples, LSB first. Then go to PARITY if parity is enabled, else STOP1.
//  - PARITY: sample one bit. Mismatch when (XOR of data bits) != sampled bit (even parity).
//  - STOP1: sample. Then go to STOP2 if cfg_stop_bits_i=1, else complete the frame.
//  - STOP2: sample, then complete the frame.
//  - Stop-bit values are not checked (no framing error). A 0 stop bit still completes the frame.
//  - Frame completion, in the cycle of the last stop sample, FSM -> IDLE:
//    - Holding register free, or rx_ready_i=1 with rx_valid_o=1 in the same cycle:
//      load the character; rx_valid_o=1 on the next cycle.
//    - Otherwise: drop the new character, keep the old data, pulse err_overflow_o for 1 cycle.
//    - err_parity_o pulses in the completion cycle on mismatch, independent of overflow.
//  - Latency: rx_valid_o rises 1 clock after the final stop-bit sample.
//  - Handshake: a transfer occurs on a posedge with rx_valid_o & rx_ready_i.
//    rx_valid_o then drops next cycle unless a frame completes in that same cycle.
//    rx_data_o is stable while rx_valid_o=1.
//  - A back-to-back start edge is accepted in the cycle after completion (IDLE re-entered).
//  - cfg_en_i=0: the FSM aborts to IDLE within 1 cycle, the partial frame is discarded and no error is
//    reported. The holding register and rx_valid_o are kept and can still be read.
//  - cfg_div_i=0: 1 clock per bit; the half period is 0, so START samples on the next clock.
// CONFIGURATION
//  - UART_RX_MAJORITY_EN defined: each sample (start, data, parity, stop) is the 2-of-3 majority of the
//    synchronised line at mid-1, mid, mid+1 clocks. Requires cfg_div_i>=2.
//    When the macro is defined and cfg_div_i<2, single sampling is used.
//  - UART_RX_MAJORITY_EN not defined: single sample at mid-bit. No extra flops are instantiated.
// TESTING
//  1. div=3, 8N1, drive 0xA5, rx_ready_i=0 -> rx_data_o=0xA5, rx_valid_o=1 one clock after the stop sample,
//     no error pulses.
//  2. div=7, 8E1, drive 0x03 with parity bit 1 -> rx_data_o=0x03, err_parity_o pulses once.
//     Then drive 0x03 with parity bit 0 -> no pulse.
//  3. div=3, hold rx_ready_i=0, send 0x11 then 0x22 -> rx_data_o stays 0x11, err_overflow_o pulses once
//     at the end of the second frame.
//     Repeat with rx_ready_i=1 in the completion cycle of 0x22 -> 0x22 is loaded, no overflow.
//  4. div=9, rx_i low for 2 clocks then high -> false start, busy_o returns to 0, rx_valid_o stays 0.
//  5. div=3, 5 data bits, 2 stop bits, line byte 0xFF pattern -> rx_data_o=0x1F.
//     Next start edge 1 clock after STOP2 completion is received correctly.
//  6. div=15, drop cfg_en_i during DATA -> busy_o=0 next cycle, no valid or error pulses.
//     Re-enable, send 0x5A -> 0x5A received.

Source files
------------

// File: rtl/udma_uart_rx_deser.sv
// uDMA UART receive deserialiser: synchronises rx_i, deframes start/data/parity/stop bits and
// offers each character through a one-entry valid/ready holding register.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority sampling around mid-bit.
module udma_uart_rx_deser #(
   parameter  int unsigned SYNC_STAGES = 2,
   localparam int unsigned DIV_W       = 16,
   localparam int unsigned DATA_W      = 8
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              rx_i,
   input  logic              cfg_en_i,
   input  logic [DIV_W-1:0]  cfg_div_i,
   input  logic [1:0]        cfg_bits_i,
   input  logic              cfg_parity_en_i,
   input  logic              cfg_stop_bits_i,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              rx_valid_o,
   input  logic              rx_ready_i,
   output logic              err_parity_o,
   output logic              err_overflow_o,
   output logic              busy_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
   } state_e;

   state_e              state_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                rx_prev_q;
   logic [DIV_W-1:0]    cnt_q;
   logic [DIV_W-1:0]    div_q;
   logic [1:0]          bits_q;
   logic                par_en_q;
   logic                stop2_q;
   logic [2:0]          bit_idx_q;
   logic [DATA_W-1:0]   shift_q;
   logic                perr_q;
   logic [DATA_W-1:0]   data_q;
   logic                valid_q;
   logic                err_par_q;
   logic                err_ovf_q;
   logic                busy_q;

   logic rx_s_c;
   logic fall_c;
   logic tick_c;
   logic sample_c;
   logic done_c;

   assign rx_s_c = sync_q[SYNC_STAGES-1];
   assign fall_c = rx_prev_q & ~rx_s_c;
   assign tick_c = (cnt_q == '0);

`ifdef UART_RX_MAJORITY_EN
   // rx_prev_q is the line one clock before mid-bit, the next-younger sync stage one clock after.
   logic rx_next_c;
   assign rx_next_c = sync_q[SYNC_STAGES-2];
   assign sample_c  = (div_q >= DIV_W'(2))
                      ? ((rx_prev_q & rx_s_c) | (rx_prev_q & rx_next_c) | (rx_s_c & rx_next_c))
                      : rx_s_c;
`else
   assign sample_c = rx_s_c;
`endif

   assign done_c = cfg_en_i & tick_c &
                   (((state_q == S_STOP1) & ~stop2_q) | (state_q == S_STOP2));

   // Line synchroniser and previous-value flop for start-edge detection.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sync_q    <= '1;
         rx_prev_q <= 1'b1;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_i};
         rx_prev_q <= rx_s_c;
      end
   end

   // Deframing FSM, baud counter and holding register.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         div_q     <= '0;
         bits_q    <= '0;
         par_en_q  <= 1'b0;
         stop2_q   <= 1'b0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         perr_q    <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         err_par_q <= 1'b0;
         err_ovf_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         err_par_q <= 1'b0;
         err_ovf_q <= 1'b0;
         if (valid_q && rx_ready_i) valid_q <= 1'b0;

         if (!cfg_en_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
         end else begin
            if (state_q != S_IDLE) cnt_q <= tick_c ? div_q : cnt_q - DIV_W'(1);
            unique case (state_q)
               S_IDLE: begin
                  if (fall_c) begin
                     state_q   <= S_START;
                     busy_q    <= 1'b1;
                     cnt_q     <= DIV_W'((17'(cfg_div_i) + 17'd1) >> 1);
                     div_q     <= cfg_div_i;
                     bits_q    <= cfg_bits_i;
                     par_en_q  <= cfg_parity_en_i;
                     stop2_q   <= cfg_stop_bits_i;
                     bit_idx_q <= '0;
                     shift_q   <= '0;
                     perr_q    <= 1'b0;
                  end
               end
               S_START: begin
                  if (tick_c) begin
                     state_q <= sample_c ? S_IDLE : S_DATA;
                     busy_q  <= ~sample_c;
                  end
               end
               S_DATA: begin
                  if (tick_c) begin
                     shift_q[bit_idx_q] <= sample_c;
                     if (bit_idx_q == 3'(3'd4 + 3'(bits_q))) begin
                        state_q <= par_en_q ? S_PARITY : S_STOP1;
                     end else begin
                        bit_idx_q <= bit_idx_q + 3'd1;
                     end
                  end
               end
               S_PARITY: begin
                  if (tick_c) begin
                     perr_q  <= (^shift_q) ^ sample_c;
                     state_q <= S_STOP1;
                  end
               end
               S_STOP1: begin
                  if (tick_c && stop2_q) state_q <= S_STOP2;
               end
               S_STOP2: ;
               default: state_q <= S_IDLE;
            endcase

            // Frame completion: stop-bit values are deliberately not checked.
            if (done_c) begin
               state_q   <= S_IDLE;
               busy_q    <= 1'b0;
               err_par_q <= perr_q;
               if (!valid_q || rx_ready_i) begin
                  data_q  <= shift_q;
                  valid_q <= 1'b1;
               end else begin
                  err_ovf_q <= 1'b1;
               end
            end
         end
      end
   end

   assign rx_data_o      = data_q;
   assign rx_valid_o     = valid_q;
   assign err_parity_o   = err_par_q;
   assign err_overflow_o = err_ovf_q;
   assign busy_o         = busy_q;

endmodule
